// File: rtl/adc_fifo_bank_pkg.sv
// Shared defaults for the ADC sample FIFO bank; THRESH is one readout window of samples.
package adc_fifo_bank_pkg;

    localparam int ADC_CHANNELS       = 8;
    localparam int ADC_WIDTH          = 16;
    localparam int ADC_DEPTH          = 256;
    localparam int ADC_SAMPLE_RATE_HZ = 36000;
    localparam int ADC_WINDOW_US      = 1000;
    localparam int ADC_THRESH         = (ADC_SAMPLE_RATE_HZ / 1000) * ADC_WINDOW_US / 1000;

    // A single channel still needs a 1-bit select port.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_fifo_bank_sample_ram.sv
// Simple dual-port sample store, one write and one registered read per cycle (read-first).
// Read data appears the cycle after i_re; contents are never reset.
module sample_ram #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 11,
    parameter int ENTRIES = 2048
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_fifo_bank.sv
// Bank of per-channel ADC sample FIFOs sharing one RAM; pops return data one cycle later.
// A write to a full channel drops the sample and flushes every channel to keep frames aligned.
module adc_fifo_bank
    import adc_fifo_bank_pkg::*;
#(
    parameter int CHANNELS = ADC_CHANNELS,
    parameter int WIDTH    = ADC_WIDTH,
    parameter int DEPTH    = ADC_DEPTH,
    parameter int THRESH   = ADC_THRESH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [idx_bits(CHANNELS)-1:0]  wr_ch,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    input  logic [idx_bits(CHANNELS)-1:0]  rd_ch,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           rd_valid,
    output logic [CHANNELS-1:0]            ch_ready,
    output logic                           frame_ready,
    output logic                           overflow,
    output logic                           underflow,
    input  logic                           clr
);

    localparam int CHW = idx_bits(CHANNELS);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int AW  = CHW + PW;
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_LVL = CW'(THRESH);

    logic [PW-1:0]       r_wr_ptr [CHANNELS];
    logic [PW-1:0]       r_rd_ptr [CHANNELS];
    logic [CW-1:0]       r_count  [CHANNELS];
    logic                r_rd_valid;
    logic [CHANNELS-1:0] r_ch_ready;
    logic                r_frame_ready;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wr_sel;
    logic                w_rd_sel;
    logic [CW-1:0]       w_wr_cnt;
    logic [CW-1:0]       w_rd_cnt;
    logic [PW-1:0]       w_wr_ptr;
    logic [PW-1:0]       w_rd_ptr;
    logic                w_same_ch;
    logic                w_wr_full;
    logic                w_rd_empty;
    logic                w_flush;
    logic                w_do_wr;
    logic                w_do_rd;
    logic                w_underflow_hit;
    logic [CHANNELS-1:0] w_thresh_hit;
    logic [WIDTH-1:0]    w_ram_rdata;

    // Out-of-range channel selects match no channel and are ignored.
    always_comb begin
        w_wr_sel     = 1'b0;
        w_rd_sel     = 1'b0;
        w_wr_cnt     = '0;
        w_rd_cnt     = '0;
        w_wr_ptr     = '0;
        w_rd_ptr     = '0;
        w_thresh_hit = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (wr_ch == CHW'(n)) begin
                w_wr_sel = 1'b1;
                w_wr_cnt = r_count[n];
                w_wr_ptr = r_wr_ptr[n];
            end
            if (rd_ch == CHW'(n)) begin
                w_rd_sel = 1'b1;
                w_rd_cnt = r_count[n];
                w_rd_ptr = r_rd_ptr[n];
            end
            w_thresh_hit[n] = (r_count[n] >= THRESH_LVL);
        end
    end

    // A pop on the full channel frees the slot being written, so that write is not an overflow.
    assign w_same_ch       = rd_en && w_rd_sel && (wr_ch == rd_ch);
    assign w_wr_full       = (w_wr_cnt == FULL_LVL);
    assign w_rd_empty      = (w_rd_cnt == '0);
    assign w_flush         = !clr && wr_en && w_wr_sel && w_wr_full && !w_same_ch;
    assign w_do_wr         = !clr && wr_en && w_wr_sel && (!w_wr_full || w_same_ch);
    assign w_do_rd         = !clr && rd_en && w_rd_sel && !w_rd_empty && !w_flush;
    assign w_underflow_hit = !clr && rd_en && w_rd_sel && w_rd_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_wr_ptr[n] <= '0;
                r_rd_ptr[n] <= '0;
                r_count[n]  <= '0;
            end
            r_rd_valid    <= 1'b0;
            r_ch_ready    <= '0;
            r_frame_ready <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_rd_valid    <= w_do_rd;
            r_ch_ready    <= w_thresh_hit;
            r_frame_ready <= &w_thresh_hit;
            if (w_underflow_hit) begin
                r_underflow <= 1'b1;
            end
            if (clr || w_flush) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    r_wr_ptr[n] <= '0;
                    r_rd_ptr[n] <= '0;
                    r_count[n]  <= '0;
                end
                r_overflow <= !clr;
                if (clr) begin
                    r_underflow <= 1'b0;
                end
            end else begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (w_do_wr && (wr_ch == CHW'(n))) begin
                        r_wr_ptr[n] <= r_wr_ptr[n] + PW'(1);
                    end
                    if (w_do_rd && (rd_ch == CHW'(n))) begin
                        r_rd_ptr[n] <= r_rd_ptr[n] + PW'(1);
                    end
                    if (w_do_wr && (wr_ch == CHW'(n)) && !(w_do_rd && (rd_ch == CHW'(n)))) begin
                        r_count[n] <= r_count[n] + CW'(1);
                    end else if (w_do_rd && (rd_ch == CHW'(n)) && !(w_do_wr && (wr_ch == CHW'(n)))) begin
                        r_count[n] <= r_count[n] - CW'(1);
                    end
                end
            end
        end
    end

    sample_ram #(
        .WIDTH   (WIDTH),
        .ADDR_W  (AW),
        .ENTRIES (CHANNELS * DEPTH)
    ) u_sample_ram (
        .clk     (clk),
        .i_we    (w_do_wr),
        .i_waddr ({wr_ch, w_wr_ptr}),
        .i_wdata (wr_data),
        .i_re    (w_do_rd),
        .i_raddr ({rd_ch, w_rd_ptr}),
        .o_rdata (w_ram_rdata)
    );

    assign rd_data     = w_ram_rdata;
    assign rd_valid    = r_rd_valid;
    assign ch_ready    = r_ch_ready;
    assign frame_ready = r_frame_ready;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_adc_fifo_bank.sv
// Bench for adc_fifo_bank: queue-based reference model checked every cycle plus pinned literal expectations.
module tb_adc_fifo_bank;

    localparam int CH = 8;
    localparam int W  = 16;
    localparam int D  = 64;
    localparam int T  = 36;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          clr     = 1'b0;
    logic          wr_en   = 1'b0;
    logic [2:0]    wr_ch   = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [2:0]    rd_ch   = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [CH-1:0] ch_ready;
    logic          frame_ready;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    adc_fifo_bank #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .DEPTH    (D),
        .THRESH   (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .ch_ready    (ch_ready),
        .frame_ready (frame_ready),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr         (clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel, outputs derived from queue sizes.
    logic [W-1:0]  mq [CH][$];
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data  = '0;
    logic [CH-1:0] m_ready = '0;
    logic          m_frame = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_udf   = 1'b0;
    logic [CH-1:0] m_rdy_now;
    logic          m_same;

    always @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            m_valid = 1'b0;
            m_ready = '0;
            m_frame = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) m_rdy_now[c] = (mq[c].size() >= T);
            m_ready = m_rdy_now;
            m_frame = &m_rdy_now;
            m_valid = 1'b0;
            if (clr) begin
                for (int c = 0; c < CH; c++) mq[c].delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                m_same = wr_en && rd_en && (wr_ch == rd_ch);
                if (rd_en && mq[rd_ch].size() == 0) m_udf = 1'b1;
                if (wr_en && mq[wr_ch].size() == D && !m_same) begin
                    for (int c = 0; c < CH; c++) mq[c].delete();
                    m_ovf = 1'b1;
                end else begin
                    if (rd_en && mq[rd_ch].size() > 0) begin
                        m_data  = mq[rd_ch].pop_front();
                        m_valid = 1'b1;
                    end
                    if (wr_en) mq[wr_ch].push_back(wr_data);
                end
            end
        end
        #1;
        chk("model_rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_valid) chk("model_rd_data", 32'(rd_data), 32'(m_data));
        chk("model_ch_ready", 32'(ch_ready), 32'(m_ready));
        chk("model_frame_ready", 32'(frame_ready), 32'(m_frame));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        chk("model_underflow", 32'(underflow), 32'(m_udf));
    end

    task automatic step(input logic r, input logic c, input logic we, input int wc,
                        input logic [W-1:0] wd, input logic re, input int rc);
        @(negedge clk);
        rst     = r;
        clr     = c;
        wr_en   = we;
        wr_ch   = 3'(wc);
        wr_data = wd;
        rd_en   = re;
        rd_ch   = 3'(rc);
    endtask

    task automatic idle();                              step(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, 0); endtask
    task automatic wr(input int c, input logic [W-1:0] d); step(1'b1, 1'b0, 1'b1, c, d, 1'b0, 0); endtask
    task automatic rd(input int c);                     step(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, c); endtask
    task automatic do_clr();                            step(1'b1, 1'b1, 1'b0, 0, '0, 1'b0, 0); endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 0);
        settle();
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_ch_ready", 32'(ch_ready), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);

        // ch3 reaches threshold, then drains in order
        for (int i = 0; i < T; i++) wr(3, 16'(16'h1000 + i));
        idle();
        settle();
        chk("thresh_ch_ready", 32'(ch_ready), 32'h08);
        chk("thresh_frame_ready", 32'(frame_ready), 32'd0);
        rd(3);
        settle();
        chk("pop1_valid", 32'(rd_valid), 32'd1);
        chk("pop1_data", 32'(rd_data), 32'h1000);
        rd(3);
        settle();
        chk("pop2_data", 32'(rd_data), 32'h1001);
        for (int i = 0; i < T - 2; i++) rd(3);
        idle();

        // All channels at threshold raise frame_ready; one pop drops it
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < T; i++) wr(c, 16'((c << 8) | i));
        idle();
        idle();
        settle();
        chk("frame_up", 32'(frame_ready), 32'd1);
        chk("frame_all_ready", 32'(ch_ready), 32'hFF);
        rd(5);
        settle();
        chk("frame_pop_data", 32'(rd_data), 32'h0500);
        idle();
        settle();
        chk("frame_down", 32'(frame_ready), 32'd0);
        chk("frame_ch_ready", 32'(ch_ready), 32'hDF);
        do_clr();
        idle();
        settle();
        chk("clr_ch_ready", 32'(ch_ready), 32'd0);

        // Overflow flushes every channel
        for (int i = 0; i < D; i++) wr(2, 16'(16'h2000 + i));
        wr(2, 16'h20FF);
        idle();
        settle();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_ch_ready", 32'(ch_ready), 32'd0);
        rd(2);
        settle();
        chk("ovf_flushed_valid", 32'(rd_valid), 32'd0);
        chk("ovf_flushed_udf", 32'(underflow), 32'd1);
        do_clr();
        settle();
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_underflow", 32'(underflow), 32'd0);

        // Pop of an empty channel leaves others intact
        wr(0, 16'h00A0);
        wr(0, 16'h00A1);
        rd(1);
        settle();
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);
        chk("empty_pop_udf", 32'(underflow), 32'd1);
        rd(0);
        settle();
        chk("other_ch_data", 32'(rd_data), 32'h00A0);
        rd(0);
        do_clr();

        // Write and pop on a full channel: no flush, oldest out, new sample last
        for (int i = 0; i < D; i++) wr(4, 16'(16'h4000 + i));
        step(1'b1, 1'b0, 1'b1, 4, 16'hBEEF, 1'b1, 4);
        settle();
        chk("full_rw_valid", 32'(rd_valid), 32'd1);
        chk("full_rw_data", 32'(rd_data), 32'h4000);
        chk("full_rw_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < D - 1; i++) rd(4);
        rd(4);
        settle();
        chk("full_rw_last", 32'(rd_data), 32'hBEEF);
        rd(4);
        do_clr();

        // Write and pop on an empty channel: no bypass
        step(1'b1, 1'b0, 1'b1, 6, 16'h6666, 1'b1, 6);
        settle();
        chk("empty_rw_valid", 32'(rd_valid), 32'd0);
        chk("empty_rw_udf", 32'(underflow), 32'd1);
        rd(6);
        settle();
        chk("empty_rw_later", 32'(rd_data), 32'h6666);

        // Write and pop on a partially filled channel
        wr(7, 16'h7000);
        wr(7, 16'h7001);
        step(1'b1, 1'b0, 1'b1, 7, 16'h7002, 1'b1, 7);
        settle();
        chk("mid_rw_data", 32'(rd_data), 32'h7000);
        rd(7);
        rd(7);
        settle();
        chk("mid_rw_tail", 32'(rd_data), 32'h7002);

        // Flush discards a concurrent pop of another channel
        do_clr();
        wr(0, 16'h0ABC);
        for (int i = 0; i < D; i++) wr(1, 16'(16'h1100 + i));
        step(1'b1, 1'b0, 1'b1, 1, 16'h11FF, 1'b1, 0);
        settle();
        chk("flush_pop_valid", 32'(rd_valid), 32'd0);
        chk("flush_pop_ovf", 32'(overflow), 32'd1);
        rd(0);
        settle();
        chk("flush_pop_gone", 32'(rd_valid), 32'd0);

        // Reset during a pop
        wr(5, 16'h5555);
        wr(5, 16'h5556);
        step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 5);
        settle();
        chk("rst_pop_valid", 32'(rd_valid), 32'd0);
        chk("rst_pop_ovf", 32'(overflow), 32'd0);
        chk("rst_pop_udf", 32'(underflow), 32'd0);
        idle();
        settle();
        chk("rst_ch_ready", 32'(ch_ready), 32'd0);
        rd(5);
        settle();
        chk("rst_count_zero", 32'(rd_valid), 32'd0);

        idle();
        idle();
        settle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
